// File: rtl/prog_loader.sv
// Program-memory writer: packs (opcode, operand-address) stream words into
// instruction words and writes them to consecutive locations from a base address.
module prog_loader #(
    parameter int AW = 5,
    parameter int OW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base,
    input  logic [AW:0]       len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [OW-1:0]     in_opcd,
    input  logic [AW-1:0]     in_adir,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [OW+AW-1:0]  mem_wdat,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   ptr_r;
    logic [AW:0]     remain_r;
    logic            xfer_s;
    logic            launch_s;

    assign xfer_s   = (state_r == LOAD) && in_valid && !abort;
    assign launch_s = (state_r == IDLE) && start && (len != LEN_ZERO);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort only matters while words are being accepted
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (len != LEN_ZERO) ? LOAD : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (xfer_s && (remain_r == LEN_ONE)) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            FLUSH:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                in_ready = !abort;
                busy     = 1'b1;
            end
            FLUSH: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        cpu_hold = busy;
    end

    // Session counters and write port; address/data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r    <= {AW{1'b0}};
            remain_r <= LEN_ZERO;
            mem_we   <= 1'b0;
            mem_addr <= {AW{1'b0}};
            mem_wdat <= {(OW+AW){1'b0}};
        end else begin
            if (launch_s) begin
                ptr_r    <= base;
                remain_r <= len;
            end else if (xfer_s) begin
                ptr_r    <= ptr_r + PTR_ONE;
                remain_r <= remain_r - LEN_ONE;
            end else begin
                ptr_r    <= ptr_r;
                remain_r <= remain_r;
            end
            if (xfer_s) begin
                mem_we   <= 1'b1;
                mem_addr <= ptr_r;
                mem_wdat <= {in_opcd, in_adir};
            end else begin
                mem_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a negedge monitor logs writes and done pulses,
// each scenario task checks outputs and the log against hand-computed values.
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] base;
    logic [5:0] len;
    logic       abort;
    logic       in_valid;
    logic [2:0] in_opcd;
    logic [4:0] in_adir;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdat;
    logic       busy;
    logic       cpu_hold;
    logic       done;

    int nvec  = 0;
    int nmiss = 0;
    int cyc   = 0;
    int done_cnt, done_cyc, ready_cnt;
    logic [4:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         wc_q[$];

    prog_loader #(.AW(5), .OW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .abort(abort), .in_valid(in_valid), .in_opcd(in_opcd), .in_adir(in_adir),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .busy(busy), .cpu_hold(cpu_hold), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdat);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (in_ready) ready_cnt = ready_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        ready_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        nvec++; if ({in_ready, mem_we, busy, cpu_hold, done} !== 5'b0) begin nmiss++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, mem_we, busy, cpu_hold, done}); end
        nvec++; if ({mem_addr, mem_wdat} !== 13'd0) begin nmiss++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdat}); end
        step();
        rst = 1'b0;
        clear_log();
        step();
        start = 1'b1; base = 5'd10; len = 6'd4;
        step();
        start = 1'b0; in_valid = 1'b1; in_opcd = 3'd1; in_adir = 5'd2;
        step();
        in_opcd = 3'd3; in_adir = 5'd4;
        step();
        in_valid = 1'b0;
        step();
        step();
        nvec++; if (busy !== 1'b1) begin nmiss++; $display("FAIL midload_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        nvec++; if ({in_ready, mem_we, busy, cpu_hold, done} !== 5'b0) begin nmiss++; $display("FAIL async_reset_ctrl: got %b want 00000", {in_ready, mem_we, busy, cpu_hold, done}); end
        nvec++; if ({mem_addr, mem_wdat} !== 13'd0) begin nmiss++; $display("FAIL async_reset_data: got %h want 0", {mem_addr, mem_wdat}); end
        step();
        rst = 1'b0;
        step();
        step();
        nvec++; if (wa_q.size() !== 2) begin nmiss++; $display("FAIL reset_wr_count: got %0d want 2", wa_q.size()); end
        nvec++; if (done_cnt !== 0) begin nmiss++; $display("FAIL reset_no_done: got %0d want 0", done_cnt); end
    endtask

    task automatic test_basic();
        logic [4:0] ea[3];
        logic [7:0] ed[3];
        ea[0] = 5'd4;  ea[1] = 5'd5;  ea[2] = 5'd6;
        ed[0] = 8'hB1; ed[1] = 8'h40; ed[2] = 8'hFF;
        clear_log();
        start = 1'b1; base = 5'd4; len = 6'd3;
        step();
        start = 1'b0;
        nvec++; if ({busy, cpu_hold, in_ready} !== 3'b111) begin nmiss++; $display("FAIL basic_start: got %b want 111", {busy, cpu_hold, in_ready}); end
        in_valid = 1'b1; in_opcd = 3'b101; in_adir = 5'd17;
        step();
        in_opcd = 3'b010; in_adir = 5'd0;
        step();
        in_opcd = 3'b111; in_adir = 5'd31;
        step();
        in_valid = 1'b0;
        nvec++; if ({busy, in_ready, mem_we, done} !== 4'b1010) begin nmiss++; $display("FAIL basic_flush: got %b want 1010", {busy, in_ready, mem_we, done}); end
        step();
        nvec++; if ({busy, cpu_hold, done} !== 3'b111) begin nmiss++; $display("FAIL basic_done: got %b want 111", {busy, cpu_hold, done}); end
        step();
        nvec++; if ({busy, cpu_hold, done} !== 3'b000) begin nmiss++; $display("FAIL basic_idle: got %b want 000", {busy, cpu_hold, done}); end
        nvec++; if (wa_q.size() !== 3) begin nmiss++; $display("FAIL basic_wr_count: got %0d want 3", wa_q.size()); end
        if (wa_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                nvec++; if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin nmiss++; $display("FAIL basic_word%0d: got %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], ea[i], ed[i]); end
            end
            nvec++; if (wc_q[1] != wc_q[0] + 1 || wc_q[2] != wc_q[1] + 1) begin nmiss++; $display("FAIL basic_consec: got cycles %0d %0d %0d want consecutive", wc_q[0], wc_q[1], wc_q[2]); end
            nvec++; if (done_cyc != wc_q[2] + 1) begin nmiss++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, wc_q[2] + 1); end
        end
        nvec++; if (done_cnt !== 1) begin nmiss++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] words[32];
        logic [4:0] ea;
        for (int i = 0; i < 32; i++) words[i] = 8'($urandom_range(0, 255));
        clear_log();
        start = 1'b1; base = 5'd30; len = 6'd32;
        step();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) step();
            in_valid = 1'b1; {in_opcd, in_adir} = words[i];
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && done_cnt == 0; k++) step();
        step();
        nvec++; if (done_cnt !== 1) begin nmiss++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
        nvec++; if (busy !== 1'b0) begin nmiss++; $display("FAIL wrap_idle: got %b want 0", busy); end
        nvec++; if (wa_q.size() !== 32) begin nmiss++; $display("FAIL wrap_wr_count: got %0d want 32", wa_q.size()); end
        if (wa_q.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                ea = 5'd30 + 5'(i);
                nvec++; if (wa_q[i] !== ea || wd_q[i] !== words[i]) begin nmiss++; $display("FAIL wrap_word%0d: got %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], ea, words[i]); end
            end
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        start = 1'b1; base = 5'd7; len = 6'd0;
        step();
        start = 1'b0;
        nvec++; if ({done, busy} !== 2'b11) begin nmiss++; $display("FAIL zero_done: got %b want 11", {done, busy}); end
        step();
        nvec++; if ({done, busy} !== 2'b00) begin nmiss++; $display("FAIL zero_idle: got %b want 00", {done, busy}); end
        step();
        nvec++; if (wa_q.size() !== 0 || ready_cnt !== 0) begin nmiss++; $display("FAIL zero_no_write: got %0d writes %0d ready want 0 0", wa_q.size(), ready_cnt); end
        nvec++; if (done_cnt !== 1) begin nmiss++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        clear_log();
        start = 1'b1; base = 5'd0; len = 6'd5;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_opcd = 3'd2; in_adir = 5'd9;
        step();
        in_opcd = 3'd6; in_adir = 5'd21;
        step();
        in_opcd = 3'd4; in_adir = 5'd3; abort = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL abort_ready: got %b want 0", in_ready); end
        nvec++; if (mem_we !== 1'b1 || mem_addr !== 5'd1 || mem_wdat !== 8'hD5) begin nmiss++; $display("FAIL abort_prev_write: got %b/%0d/%h want 1/1/d5", mem_we, mem_addr, mem_wdat); end
        step();
        abort = 1'b0; in_valid = 1'b0;
        nvec++; if ({busy, in_ready, mem_we} !== 3'b000) begin nmiss++; $display("FAIL abort_idle: got %b want 000", {busy, in_ready, mem_we}); end
        step();
        step();
        step();
        nvec++; if (wa_q.size() !== 2 || done_cnt !== 0) begin nmiss++; $display("FAIL abort_totals: got %0d writes %0d done want 2 0", wa_q.size(), done_cnt); end
        if (wa_q.size() == 2) begin
            nvec++; if (wa_q[0] !== 5'd0 || wd_q[0] !== 8'h49) begin nmiss++; $display("FAIL abort_word0: got %0d/%h want 0/49", wa_q[0], wd_q[0]); end
        end
    endtask

    task automatic test_ignored_start();
        clear_log();
        start = 1'b1; base = 5'd0; len = 6'd3;
        step();
        in_valid = 1'b1; start = 1'b0; in_opcd = 3'd1; in_adir = 5'd1;
        step();
        start = 1'b1; base = 5'd9; len = 6'd2; in_opcd = 3'd2; in_adir = 5'd2;
        step();
        start = 1'b0; in_opcd = 3'd3; in_adir = 5'd3;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && done_cnt == 0; k++) step();
        step();
        nvec++; if (wa_q.size() !== 3 || done_cnt !== 1) begin nmiss++; $display("FAIL ign_totals: got %0d writes %0d done want 3 1", wa_q.size(), done_cnt); end
        if (wa_q.size() == 3) begin
            nvec++; if (wa_q[1] !== 5'd1 || wa_q[2] !== 5'd2) begin nmiss++; $display("FAIL ign_addr: got %0d %0d want 1 2", wa_q[1], wa_q[2]); end
            nvec++; if (wd_q[2] !== 8'h63) begin nmiss++; $display("FAIL ign_data: got %h want 63", wd_q[2]); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = 5'd0; len = 6'd0; abort = 1'b0;
        in_valid = 1'b0; in_opcd = 3'd0; in_adir = 5'd0;
        clear_log();
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_abort();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
